// File: rtl/serial_adder_if.sv
// Request/response bundle for the bit-serial adder.
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, carry);
    modport slave  (input start, a, b, sub, output busy, done, sum, carry);
`else
    modport master (output start, a, b, input busy, done, sum, carry);
    modport slave  (input start, a, b, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus carry flop, WIDTH cycles per result.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (carry then reports borrow).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_q;
    logic [CW-1:0]    cnt;
    logic             c, carry_q, sub_q, sub_in;
    logic             accept, last, b0, s, c_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Subtract is a + ~b + 1: invert b per bit, the +1 comes from the preset carry.
    assign b0    = b_sr[0] ^ sub_q;
    assign s     = a_sr[0] ^ b0 ^ c;
    assign c_nxt = (a_sr[0] & b0) | (c & (a_sr[0] ^ b0));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = bus.start ? SHIFT : IDLE;
            SHIFT:      if (last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            c       <= 1'b0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sr   <= bus.a;
                b_sr   <= bus.b;
                res_sr <= '0;
                c      <= sub_in;
                sub_q  <= sub_in;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {s, res_sr[WIDTH-1:1]};
                c      <= c_nxt;
                if (last) begin
                    // Result registers only move here, so they stay stable through SHIFT.
                    sum_q   <= {s, res_sr[WIDTH-1:1]};
                    carry_q <= c_nxt ^ sub_q;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule
